snes_reader: RTL and testbench
==============================

# snes_reader

Polls one SNES/NES game controller over its latch/clock/data serial interface and presents the 12 decoded buttons as a registered parallel word. One instance sits upstream of each player's input logic: it drives the controller's strobe-latch and shift-clock pins, and its `Buttons`/`Valid` outputs feed the per-player movement logic.

## Interface
Parameters:
- `UNIT_CYCLES`, default 150: Clock cycles per protocol time unit (6 µs at 25 MHz). Must be ≥ 2.
- `POLL_CYCLES`, default 416_667: cycles from one latch rise to the next (60 Hz at 25 MHz). Must be ≥ 33·`UNIT_CYCLES`+1.

Ports:
- `Clock`, input, 1: system clock. One clock domain.
- `Reset`, input, 1: synchronous, active-high reset.
- `NData`, input, 1: controller serial data, active-low (0 = pressed), asynchronous to `Clock`.
- `NStrobe_Latch`, output, 1: controller latch, active-high pulse.
- `NShift_Clock`, output, 1: controller shift clock, idles high.
- `Buttons`, output, 12: active-high button word. Bit order [0..11] = B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R.
- `Valid`, output, 1: one-cycle pulse when `Buttons` has been updated.

## Operation
- `NData` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- FSM states: IDLE, LATCH, SETTLE, CLK_LO, CLK_HI, DONE.
- IDLE: latch 0, clock 1. Waits for the poll counter to expire, then goes to LATCH.
- LATCH: latch 1 for 2·U cycles, then SETTLE.
- SETTLE: latch 0 for U cycles. Bit 0 is sampled on the last cycle, then CLK_LO.
- CLK_LO: clock 0 for U cycles, then CLK_HI.
- CLK_HI: clock 1 for U cycles. The current bit index (1..15) is sampled on the last cycle. If the index is 15, go to DONE; otherwise go to CLK_LO.
- DONE: one cycle. `Buttons` ← ~raw[11:0], `Valid` = 1, then IDLE.
- Raw bits 12–15 are shifted in and discarded.
- A poll therefore produces exactly one latch pulse and 15 falling edges on `NShift_Clock`.
- `Buttons` holds its value between polls.
- Counters: unit counter ⌈log2(2·U)⌉ bits, bit counter 4 bits, poll counter ⌈log2(POLL_CYCLES)⌉ bits. The poll counter is free-running from latch rise and wraps at `POLL_CYCLES`−1. It is independent of FSM progress.

## Timing
- Reset values: `NStrobe_Latch`=0, `NShift_Clock`=1, `Buttons`=0, `Valid`=0, FSM=IDLE, synchronizer flops=1, all counters=0.
- Let t0 be the first `Clock` edge at which `Reset` is sampled low. `NStrobe_Latch` rises at t0 with no initial wait.
- All times below are in cycles relative to the latch rise at t0. U = `UNIT_CYCLES`.
- Latch high during [t0, t0+2U).
- First `NShift_Clock` fall at t0+3U. Falls repeat every 2U cycles, 15 in total.
- `Valid` high for exactly the cycle t0+33U. `Buttons` changes on the same edge.
- Next latch rise at t0+`POLL_CYCLES`.
- `NData` latency: the sample reflects the pin as it was 2 cycles earlier. The sample point sits U cycles after the last clock edge, so data setup is guaranteed.
- Reset mid-poll:
  - On the next edge all outputs return to reset values, including `Buttons` cleared.
  - No `Valid` is issued for the aborted poll.
  - A new poll starts at the first edge with `Reset` low.
- Reset while `Valid` is high: `Valid` drops on the next edge.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- `snes_pkg` holds:
  - the FSM state enum;
  - button index constants (`BTN_B`=0 … `BTN_R`=11);
  - `SNES_BITS`=16 and `SNES_BUTTONS`=12;
  - the default `UNIT_CYCLES` and `POLL_CYCLES` values.
- Sub-module `sync2` is the generic 2-flop synchronizer, with the reset value as a parameter (1 here).
- Everything else stays in `snes_reader`.

## Test plan
Simulation settings: U=4, `POLL_CYCLES`=200, with a behavioural controller model that shifts on the rising edge of `NShift_Clock`.
1. Hold `Reset` for 5 cycles, then release → outputs hold reset values during reset. Latch rises at the first low-reset edge and stays high for exactly 8 cycles.
2. Model with nothing pressed (raw 16'hFFFF) → `Valid` pulse at t0+132 with `Buttons`=12'h000. Exactly 15 shift-clock falls are seen.
3. B and R pressed (raw bits 0 and 11 low) → `Buttons`=12'h801.
4. Raw 16'hA5A5 → `Buttons`=12'hA5A. Changing raw bits 12–15 to 0 gives the same result.
5. Assert `Reset` during CLK_HI of bit 7 → next edge shows latch 0, clock 1, `Buttons` 0, and no `Valid`. After release, the new latch rises at the first low-reset edge.
6. Run 5 consecutive polls with changing patterns → latch rises are exactly 200 cycles apart, `Buttons` updates only on `Valid` cycles, and `Valid` is never wider than 1 cycle.

Source files
------------

// File: rtl/snes_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snes_pkg                                                           |
// | Shared constants and FSM encoding for the SNES controller reader.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package snes_pkg;

    localparam int SNES_BITS           = 16;
    localparam int SNES_BUTTONS        = 12;
    localparam int DEFAULT_UNIT_CYCLES = 150;
    localparam int DEFAULT_POLL_CYCLES = 416_667;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_CLK_HI = 3'd4,
        ST_DONE   = 3'd5
    } snes_state_e;

endpackage
`default_nettype wire

// File: rtl/snes_reader_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync2                                                              |
// | Generic two-flop synchronizer with a parameterised reset value.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync2
    import snes_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/snes_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snes_reader                                                        |
// | Polls a SNES/NES pad over latch/clock/data, outputs 12 buttons.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module snes_reader
    import snes_pkg::*;
#(
    parameter int UNIT_CYCLES = DEFAULT_UNIT_CYCLES,
    parameter int POLL_CYCLES = DEFAULT_POLL_CYCLES
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    NData,
    output logic                    NStrobe_Latch,
    output logic                    NShift_Clock,
    output logic [SNES_BUTTONS-1:0] Buttons,
    output logic                    Valid
);

    localparam int UNIT_W = $clog2(2 * UNIT_CYCLES);
    localparam int POLL_W = $clog2(POLL_CYCLES);

    localparam logic [UNIT_W-1:0] UNIT_LAST  = UNIT_W'(UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0] LATCH_LAST = UNIT_W'(2 * UNIT_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [3:0]        BIT_LAST   = 4'(SNES_BITS - 1);

    snes_state_e             state_q, state_d;
    logic [UNIT_W-1:0]       unit_q, unit_d;
    logic [3:0]              bit_q, bit_d;
    logic [POLL_W-1:0]       poll_q, poll_d;
    logic [SNES_BITS-1:0]    raw_q, raw_d;
    logic [SNES_BUTTONS-1:0] buttons_q, buttons_d;
    logic                    latch_q, latch_d;
    logic                    sclk_q, sclk_d;
    logic                    valid_q, valid_d;

    logic                    w_data_sync;
    logic                    w_poll_due;
    logic                    w_unit_last;
    logic [SNES_BITS-1:0]    w_raw_shift;

    sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync_data (
        .clk (Clock),
        .rst (Reset),
        .i_d (NData),
        .o_q (w_data_sync)
    );

    assign w_poll_due  = (poll_q == '0);
    assign w_unit_last = (unit_q == UNIT_LAST);
    // Bits arrive LSB first, so after 16 shifts raw bit 0 lands at index 0.
    assign w_raw_shift = {w_data_sync, raw_q[SNES_BITS-1:1]};

    always_comb begin
        state_d   = state_q;
        unit_d    = '0;
        bit_d     = bit_q;
        raw_d     = raw_q;
        buttons_d = buttons_q;
        poll_d    = (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (w_poll_due) begin
                    state_d = ST_LATCH;
                    bit_d   = '0;
                end
            end
            ST_LATCH: begin
                if (unit_q == LATCH_LAST) state_d = ST_SETTLE;
                else                      unit_d  = unit_q + 1'b1;
            end
            ST_SETTLE: begin
                if (w_unit_last) begin
                    state_d = ST_CLK_LO;
                    raw_d   = w_raw_shift;
                    bit_d   = bit_q + 1'b1;
                end else begin
                    unit_d  = unit_q + 1'b1;
                end
            end
            ST_CLK_LO: begin
                if (w_unit_last) state_d = ST_CLK_HI;
                else             unit_d  = unit_q + 1'b1;
            end
            ST_CLK_HI: begin
                if (w_unit_last) begin
                    raw_d = w_raw_shift;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d   = ST_DONE;
                        buttons_d = ~w_raw_shift[SNES_BUTTONS-1:0];
                    end else begin
                        state_d   = ST_CLK_LO;
                    end
                end else begin
                    unit_d = unit_q + 1'b1;
                end
            end
            ST_DONE: begin
                // A minimum-length poll period can expire while still here.
                if (w_poll_due) begin
                    state_d = ST_LATCH;
                    bit_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        latch_d = (state_d == ST_LATCH);
        sclk_d  = (state_d != ST_CLK_LO);
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            unit_q    <= '0;
            bit_q     <= '0;
            poll_q    <= '0;
            raw_q     <= '0;
            buttons_q <= '0;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            unit_q    <= unit_d;
            bit_q     <= bit_d;
            poll_q    <= poll_d;
            raw_q     <= raw_d;
            buttons_q <= buttons_d;
            latch_q   <= latch_d;
            sclk_q    <= sclk_d;
            valid_q   <= valid_d;
        end
    end

    assign NStrobe_Latch = latch_q;
    assign NShift_Clock  = sclk_q;
    assign Buttons       = buttons_q;
    assign Valid         = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_snes_reader                                                     |
// | Scoreboard bench with a behavioural pad model, U=4, poll=200.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_snes_reader;

    localparam int U    = 4;
    localparam int POLL = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ndata;
    logic        latch;
    logic        sclk;
    logic [11:0] buttons;
    logic        valid;

    logic [15:0] pad_raw = 16'hFFFF;
    logic [15:0] pad_sr  = 16'hFFFF;

    logic [11:0] sb_q[$];
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          n_valid = 0;
    int          cyc     = 0;
    logic        rst_seen = 1'b1;

    always #5 clk = ~clk;

    snes_reader #(
        .UNIT_CYCLES (U),
        .POLL_CYCLES (POLL)
    ) dut (
        .Clock         (clk),
        .Reset         (rst),
        .NData         (ndata),
        .NStrobe_Latch (latch),
        .NShift_Clock  (sclk),
        .Buttons       (buttons),
        .Valid         (valid)
    );

    // Pad model: latch loads the word, each rising shift clock advances it.
    always @(posedge latch or posedge sclk) begin
        if (latch) pad_sr <= pad_raw;
        else       pad_sr <= {1'b1, pad_sr[15:1]};
    end
    assign ndata = pad_sr[0];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: scoreboard pops on Valid plus protocol timing checks.
    logic        latch_p = 1'b0, sclk_p = 1'b1, valid_p = 1'b0;
    logic [11:0] buttons_p = '0;
    int          rise_cyc = 0, falls = 0;
    logic        have_rise = 1'b0;

    always @(negedge clk) begin
        if (rst_seen) begin
            have_rise = 1'b0;
        end else begin
            if (latch && !latch_p) begin
                if (have_rise) check("poll_period", cyc - rise_cyc, POLL);
                rise_cyc  = cyc;
                have_rise = 1'b1;
                falls     = 0;
            end
            if (!latch && latch_p && have_rise) check("latch_width", cyc - rise_cyc, 2 * U);
            if (!sclk && sclk_p) falls++;
            if (valid) begin
                n_valid++;
                check("valid_width", valid_p, 0);
                check("valid_offset", cyc - rise_cyc, 33 * U);
                check("shift_falls", falls, 15);
                check("valid_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) check("buttons", buttons, sb_q.pop_front());
            end else begin
                check("buttons_hold", buttons, buttons_p);
            end
        end
        latch_p   = latch;
        sclk_p    = sclk;
        valid_p   = valid;
        buttons_p = buttons;
    end

    task automatic wait_valid();
        int start = n_valid;
        int k = 0;
        while (n_valid == start && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("valid_timeout", n_valid != start, 1);
    endtask

    task automatic run_poll(input logic [15:0] raw, input logic [11:0] exp_btn);
        pad_raw = raw;
        sb_q.push_back(exp_btn);
        wait_valid();
    endtask

    initial begin
        int k;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_latch", latch, 0);
            check("rst_sclk", sclk, 1);
            check("rst_buttons", buttons, 0);
            check("rst_valid", valid, 0);
        end

        pad_raw = 16'hFFFF;
        sb_q.push_back(12'h000);
        rst = 1'b0;
        @(negedge clk);
        check("latch_at_t0", latch, 1);
        wait_valid();

        run_poll(16'hF7FE, 12'h801);
        run_poll(16'hA5A5, 12'hA5A);
        run_poll(16'h05A5, 12'hA5A);

        // Abort a poll in CLK_HI of bit 7; nothing is queued for it.
        pad_raw = 16'h0000;
        k = 0;
        while (!latch && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("abort_rise_seen", latch, 1);
        repeat (65) @(negedge clk);
        check("abort_in_clk_hi", sclk, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_latch", latch, 0);
        check("abort_sclk", sclk, 1);
        check("abort_buttons", buttons, 0);
        check("abort_valid", valid, 0);
        repeat (2) @(negedge clk);

        pad_raw = 16'hFFF0;
        sb_q.push_back(12'h00F);
        rst = 1'b0;
        @(negedge clk);
        check("latch_after_abort", latch, 1);
        wait_valid();

        run_poll(16'h0000, 12'hFFF);
        run_poll(16'h1234, 12'hDCB);
        run_poll(16'hFEDC, 12'h123);
        run_poll(16'hF0F0, 12'hF0F);

        repeat (80) @(negedge clk);
        check("queue_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
